// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph plotter: FSM encoding, segment field layout and
// the packed segment tables for the standard digit glyphs.
package glyph_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Segment entry layout, LSB first: len, yoff, xoff, vert.
    localparam int SEG_LEN_LSB = 0;

    function automatic int seg_w(input int off_w);
        return 1 + 3 * off_w;
    endfunction

    function automatic int seg_yoff_lsb(input int off_w);
        return off_w;
    endfunction

    function automatic int seg_xoff_lsb(input int off_w);
        return 2 * off_w;
    endfunction

    function automatic int seg_vert_bit(input int off_w);
        return 3 * off_w;
    endfunction

    localparam int STD_OFF_W = 5;
    localparam int STD_SEG_W = 1 + 3 * STD_OFF_W;

    function automatic logic [STD_SEG_W-1:0] pack_seg(
        input logic                 vert,
        input logic [STD_OFF_W-1:0] xoff,
        input logic [STD_OFF_W-1:0] yoff,
        input logic [STD_OFF_W-1:0] len
    );
        return {vert, xoff, yoff, len};
    endfunction

    // "11": two full-height vertical strokes.
    localparam logic [2*STD_SEG_W-1:0] GLYPH_11 = {
        pack_seg(1'b1, 5'd20, 5'd7, 5'd15),
        pack_seg(1'b1, 5'd8,  5'd7, 5'd15)
    };
    localparam int GLYPH_11_SEGS = 2;

endpackage

// File: rtl/glyph_line_walker.sv
// Step counter along one segment; offsets are registered state, no path from ready.
// Advances one step per accepted pixel; holds while ready is low.
module glyph_line_walker #(
    parameter int OFF_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    input  logic             ready,
    input  logic             vert,
    input  logic [OFF_W-1:0] len,
    output logic             last,
    output logic [OFF_W-1:0] dx,
    output logic [OFF_W-1:0] dy
);

    logic [OFF_W-1:0] step;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            step <= '0;
        end else if (clr) begin
            step <= '0;
        end else if (en && ready) begin
            step <= step + OFF_W'(1);
        end
    end

    // len is never zero while walking; zero-length entries are skipped upstream.
    assign last = (step == len - OFF_W'(1));
    assign dx   = vert ? '0 : step;
    assign dy   = vert ? step : '0;

endmodule

// File: rtl/glyph_segment_drawer.sv
// Table-driven glyph plotter: first pixel two cycles after start, then one per accepted cycle.
// plot/xOut/yOut hold while ready is low; start is only honoured in IDLE.
module glyph_segment_drawer
    import glyph_pkg::*;
#(
    parameter int MAX_SEGS = 8,
    parameter int OFF_W    = 5,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              start,
    input  logic [X_W-1:0]                    xIn,
    input  logic [Y_W-1:0]                    yIn,
    input  logic [$clog2(MAX_SEGS+1)-1:0]     seg_count,
    input  logic [MAX_SEGS*seg_w(OFF_W)-1:0]  seg_table,
    input  logic                              ready,
    output logic                              plot,
    output logic [X_W-1:0]                    xOut,
    output logic [Y_W-1:0]                    yOut,
    output logic                              busy,
    output logic                              done
);

    localparam int SEG_W    = seg_w(OFF_W);
    localparam int CNT_W    = $clog2(MAX_SEGS + 1);
    localparam int YOFF_LSB = seg_yoff_lsb(OFF_W);
    localparam int XOFF_LSB = seg_xoff_lsb(OFF_W);
    localparam int VERT_BIT = seg_vert_bit(OFF_W);

    state_t                    state;
    logic [X_W-1:0]            xo;
    logic [Y_W-1:0]            yo;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          idx;
    logic [MAX_SEGS*SEG_W-1:0] tbl;

    logic [SEG_W-1:0] cur;
    logic             cur_vert;
    logic [OFF_W-1:0] cur_xoff;
    logic [OFF_W-1:0] cur_yoff;
    logic [OFF_W-1:0] cur_len;
    logic             last;
    logic [OFF_W-1:0] dx;
    logic [OFF_W-1:0] dy;

    always_comb begin
        cur = '0;
        for (int i = 0; i < MAX_SEGS; i++) begin
            if (idx == CNT_W'(i)) begin
                cur = tbl[i*SEG_W +: SEG_W];
            end
        end
    end

    assign cur_vert = cur[VERT_BIT];
    assign cur_xoff = cur[XOFF_LSB +: OFF_W];
    assign cur_yoff = cur[YOFF_LSB +: OFF_W];
    assign cur_len  = cur[SEG_LEN_LSB +: OFF_W];

    glyph_line_walker #(
        .OFF_W (OFF_W)
    ) u_walker (
        .clk    (clk),
        .resetn (resetn),
        .clr    (state == S_LOAD),
        .en     ((state == S_DRAW) && plot),
        .ready  (ready),
        .vert   (cur_vert),
        .len    (cur_len),
        .last   (last),
        .dx     (dx),
        .dy     (dy)
    );

    // Sums deliberately wrap at the screen width; no clipping.
    assign xOut = xo + X_W'(cur_xoff) + X_W'(dx);
    assign yOut = yo + Y_W'(cur_yoff) + Y_W'(dy);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
            xo    <= '0;
            yo    <= '0;
            tbl   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xo    <= xIn;
                        yo    <= yIn;
                        tbl   <= seg_table;
                        cnt   <= (seg_count > CNT_W'(MAX_SEGS)) ? CNT_W'(MAX_SEGS) : seg_count;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (idx >= cnt) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (cur_len == '0) begin
                        idx <= idx + CNT_W'(1);
                    end else begin
                        plot  <= 1'b1;
                        state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (plot && ready && last) begin
                        plot  <= 1'b0;
                        idx   <= idx + CNT_W'(1);
                        state <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
